hdmi_rd_prefetch: RTL

Prefetch buffer between the DDR read port and the HDMI sync/timing generator. Issues burst read requests for one frame of RGB565 pixels, stores returned words in an internal FIFO, and serves the timing generator's per-pixel read strobe with fixed one-cycle latency. The generator's vsync restarts the frame: all buffered and in-flight data is discarded and fetching restarts at `BASE_ADDR`.

---
 rtl/hdmi_rd_prefetch.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hdmi_rd_prefetch.sv
// Prefetch FIFO between the DDR burst-read port and the HDMI timing generator.
// A rising vsync discards buffered and in-flight words and restarts fetching at BASE_ADDR.
module hdmi_rd_prefetch #(
   parameter int unsigned        DATA_W       = 16,
   parameter int unsigned        ADDR_W       = 28,
   parameter int unsigned        FIFO_DEPTH   = 1024,
   parameter int unsigned        BURST_LEN    = 64,
   parameter int unsigned        FRAME_PIXELS = 921600,
   parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
   parameter int unsigned        ADDR_STEP    = 2,
   localparam int unsigned       LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vs,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   output logic [7:0]        req_len,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_data,
   output logic [LVL_W-1:0]  fifo_level,
   output logic [15:0]       underflow_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned ISS_W = $clog2(FRAME_PIXELS + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFlush} state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_vs_d;
   logic                r_req_valid;
   logic [ADDR_W-1:0]   r_req_addr;
   logic [ISS_W-1:0]    r_issued;
   logic [LVL_W-1:0]    r_outstanding;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [LVL_W-1:0]    r_level;
   logic [DATA_W-1:0]   r_rd_data;
   logic [15:0]         r_uf_cnt;

   logic                w_vs_rise;
   logic                w_run;
   logic                w_flush;
   logic                w_frame_start;
   logic                w_hs;
   logic                w_rsp_take;
   logic                w_fifo_wr;
   logic                w_fifo_rd;
   logic                w_credit_ok;
   logic                w_req_set;

   assign w_vs_rise = vs & ~r_vs_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_vs_d  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vs_d  <= vs;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_flush       = 1'b0;
      w_frame_start = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_vs_rise) begin
               w_state_nxt   = StRun;
               w_frame_start = 1'b1;
            end
         end
         StRun: begin
            if (w_vs_rise) begin
               w_state_nxt = (r_outstanding != '0 || r_req_valid) ? StDrain : StFlush;
            end
         end
         StDrain: begin
            // Later vsync edges are ignored until every in-flight word is gone.
            if (r_outstanding == '0 && !r_req_valid) w_state_nxt = StFlush;
         end
         StFlush: begin
            w_state_nxt = StRun;
            w_flush     = 1'b1;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_run       = (r_state == StRun);
      w_hs        = r_req_valid & req_ready;
      w_rsp_take  = rsp_valid && (r_state == StRun || r_state == StDrain) && r_outstanding != '0;
      w_fifo_wr   = rsp_valid && w_run && (r_level != LVL_W'(FIFO_DEPTH));
      // Empty test uses the pre-write level: same-cycle bypass is not offered.
      w_fifo_rd   = rd_en && w_run && (r_level != '0);
      // Credit counts both buffered and promised words so a response always has room.
      w_credit_ok = (32'(r_level) + 32'(r_outstanding) + BURST_LEN) <= FIFO_DEPTH;
      w_req_set   = w_run && !w_vs_rise && !r_req_valid &&
                    (32'(r_issued) < FRAME_PIXELS) && w_credit_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_valid <= 1'b0;
         r_req_addr  <= BASE_ADDR;
         r_issued    <= '0;
      end else begin
         if (w_flush || w_frame_start) begin
            r_issued   <= '0;
            r_req_addr <= BASE_ADDR;
         end else if (w_hs) begin
            r_issued   <= r_issued + ISS_W'(BURST_LEN);
            r_req_addr <= r_req_addr + ADDR_W'(BURST_LEN * ADDR_STEP);
         end
         if (w_hs) begin
            r_req_valid <= 1'b0;
         end else if (w_req_set) begin
            r_req_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= '0;
      end else begin
         r_outstanding <= r_outstanding
                          + (w_hs ? LVL_W'(BURST_LEN) : LVL_W'(0))
                          - (w_rsp_take ? LVL_W'(1) : LVL_W'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (w_fifo_wr) r_mem[r_wr_ptr] <= rsp_data;
   end

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_level <= r_level + LVL_W'(w_fifo_wr) - LVL_W'(w_fifo_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
         r_uf_cnt  <= '0;
      end else if (rd_en) begin
         if (w_fifo_rd) begin
            r_rd_data <= r_mem[r_rd_ptr];
         end else begin
            r_rd_data <= '0;
            if (r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(rsp_valid && r_state == StRun && r_level == LVL_W'(FIFO_DEPTH)));

   assign rd_data       = r_rd_data;
   assign req_valid     = r_req_valid;
   assign req_addr      = r_req_addr;
   assign req_len       = 8'(BURST_LEN);
   assign fifo_level    = r_level;
   assign underflow_cnt = r_uf_cnt;

endmodule
